ipif_bus_master: RTL and testbench
==================================

IPIF_BUS_MASTER -- requirements
Module: ipif_bus_master

Interface
REQ-001 SHALL have parameter NUM_CE, default 2, number of register chip-enables driven.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum number of ACCESS cycles to wait for an ack.
REQ-003 SHALL have one clock and an asynchronous active-low reset: Bus2IP_Clk in 1 clock; Bus2IP_Resetn in 1 reset.
REQ-004 SHALL have ports cmd_valid in 1 request; cmd_ready out 1 accept; cmd_write in 1 1=write/0=read; cmd_reg in clog2(NUM_CE) register index; cmd_data in 32 write data; cmd_be in 4 byte enables.
REQ-005 SHALL have ports resp_valid out 1 response present; resp_ready in 1 response consumed; resp_data out 32 read data; resp_err out 1 slave error or timeout; resp_timeout out 1 timeout flag.
REQ-006 SHALL have ports Bus2IP_Data out 32; Bus2IP_BE out 4; Bus2IP_RdCE out NUM_CE; Bus2IP_WrCE out NUM_CE; IP2Bus_Data in 32; IP2Bus_RdAck in 1; IP2Bus_WrAck in 1; IP2Bus_Error in 1.

Function
REQ-007 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-008 SHALL assert cmd_ready only in IDLE; a command is accepted on a rising edge where cmd_valid and cmd_ready are both 1, and all cmd_* fields are registered at that edge.
REQ-009 SHALL, in SETUP (exactly 1 cycle), drive Bus2IP_Data/Bus2IP_BE from the registered command with both CE vectors 0.
REQ-010 SHALL, in ACCESS, assert one-hot CE bit NUM_CE-1-cmd_reg (register 0 maps to the MSB; with NUM_CE=2, reg0=2'b10 and reg1=2'b01): WrCE for writes, RdCE for reads, and hold Data/BE stable.
REQ-011 SHALL leave ACCESS on the first edge where the matching ack (WrAck for write, RdAck for read) is 1; it SHALL ignore the non-matching ack and any ack seen in IDLE, SETUP or RESP.
REQ-012 SHALL capture IP2Bus_Data (reads only; writes return 0) and IP2Bus_Error into resp_data/resp_err on the acked edge, and SHALL deassert the CE vectors in the next cycle.
REQ-013 SHALL hold resp_valid=1 in RESP with stable resp_* until resp_ready=1, then return to IDLE; resp_valid and resp_ready high in the same cycle complete it, giving a back-to-back command minimum of 4 cycles.
REQ-014 SHALL treat a simultaneous matching ack and timeout expiry as an ack (ack wins).
REQ-015 SHALL keep the outputs combinationally independent of cmd_valid and resp_ready, so all bus outputs are registered or FSM-decoded.

Reset
REQ-016 SHALL, while Bus2IP_Resetn=0, force immediately (asynchronously) state=IDLE, CE vectors=0, Bus2IP_Data=0, Bus2IP_BE=0, resp_valid=0, resp_data=0, resp_err=0, resp_timeout=0, cmd_ready=0.
REQ-017 SHALL, on reset assertion mid-ACCESS, drop the CEs at once and discard the transaction with no response; cmd_ready SHALL rise on the first edge after deassertion.

Configuration
REQ-018 SHALL, with macro IPIF_MASTER_TIMEOUT_EN defined, count ACCESS cycles and, after TIMEOUT_CYCLES cycles with no matching ack, end ACCESS with resp_err=1, resp_timeout=1, resp_data=0.
REQ-019 SHALL, without IPIF_MASTER_TIMEOUT_EN, wait in ACCESS indefinitely, tie resp_timeout to 0, and contain no timeout counter.

Structure
REQ-020 SHALL place the FSM state enum, the CE-index mapping function and the default TIMEOUT_CYCLES constant in shared package ipif_pkg.
REQ-021 SHALL use one sub-module, ipif_timeout_counter (load/enable/expire), instantiated only when IPIF_MASTER_TIMEOUT_EN is defined.

Verification
REQ-022 SHALL verify: write reg1 data 2 with the slave acking after 1 cycle -> WrCE=2'b01 for exactly one ACCESS cycle, Data=2 one cycle earlier, resp_err=0.
REQ-023 SHALL verify: read reg0 with the slave returning 0x00000005 and a 3-cycle ack delay -> RdCE=2'b10 for 3 cycles, resp_data=0x5.
REQ-024 SHALL verify: write reg0 with RdAck pulsed then WrAck 2 cycles later -> RdAck ignored, completion on WrAck.
REQ-025 SHALL verify: read with IP2Bus_Error=1 at ack -> resp_err=1, resp_timeout=0.
REQ-026 SHALL verify: with IPIF_MASTER_TIMEOUT_EN, no ack -> CE deasserted after 16 cycles, resp_err=1, resp_timeout=1.
REQ-027 SHALL verify: Bus2IP_Resetn driven low in ACCESS, then released -> CEs 0 immediately, no resp_valid, next command proceeds normally.

Source files
------------

// File: rtl/ipif_pkg.sv
// ipif_pkg: shared definitions for the IPIF bus master.
//   state_t                : master FSM states (IDLE -> SETUP -> ACCESS -> RESP)
//   TIMEOUT_CYCLES_DEFAULT : default ACCESS-cycle budget before a timeout
//   ce_bit()               : maps a register index to its chip-enable bit (reg 0 -> MSB)
package ipif_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;
   localparam int TIMEOUT_CYCLES_DEFAULT = 16;
   function automatic int ce_bit(input int num_ce, input int reg_idx);
      return num_ce - 1 - reg_idx;
   endfunction
endpackage

// File: rtl/ipif_timeout_counter.sv
// ipif_timeout_counter: counts ACCESS cycles and flags the last permitted one.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the count (asserted in the cycle before ACCESS)
//   enable     : count this cycle (asserted throughout ACCESS)
//   expire     : high in the CYCLES-th enabled cycle since load
module ipif_timeout_counter
   import ipif_pkg::*;
#(
   parameter int CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic expire
);
   localparam int W = $clog2(CYCLES + 1);
   logic [W-1:0] cnt;
   assign expire = enable && (cnt == W'(CYCLES - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= '0;
      else if (enable && !expire) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/ipif_bus_master.sv
// ipif_bus_master: single-outstanding command master driving an IPIF register bus.
//   Bus2IP_Clk, Bus2IP_Resetn   : clock, asynchronous active-low reset
//   cmd_*                       : command request (valid/ready handshake)
//   resp_*                      : response (valid/ready handshake), error and timeout flags
//   Bus2IP_* / IP2Bus_*         : IPIF slave-side data, byte enables, chip enables, acks
// Optional feature macro IPIF_MASTER_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES
// cycles without the matching ack; without it ACCESS waits indefinitely.
module ipif_bus_master
   import ipif_pkg::*;
#(
   parameter int NUM_CE         = 2,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   localparam int RW            = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
   input  logic              Bus2IP_Clk,
   input  logic              Bus2IP_Resetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [RW-1:0]     cmd_reg,
   input  logic [31:0]       cmd_data,
   input  logic [3:0]        cmd_be,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic              resp_timeout,
   output logic [31:0]       Bus2IP_Data,
   output logic [3:0]        Bus2IP_BE,
   output logic [NUM_CE-1:0] Bus2IP_RdCE,
   output logic [NUM_CE-1:0] Bus2IP_WrCE,
   input  logic [31:0]       IP2Bus_Data,
   input  logic              IP2Bus_RdAck,
   input  logic              IP2Bus_WrAck,
   input  logic              IP2Bus_Error
);
   state_t            state, next;
   logic              wr_q;
   logic [RW-1:0]     reg_q;
   logic              ack, expire;
   logic [NUM_CE-1:0] ce_hot;
   // only the ack matching the command direction counts
   assign ack = wr_q ? IP2Bus_WrAck : IP2Bus_RdAck;
   assign ce_hot = NUM_CE'(1) << ce_bit(NUM_CE, int'(reg_q));
   assign Bus2IP_WrCE = (state == ACCESS && wr_q) ? ce_hot : '0;
   assign Bus2IP_RdCE = (state == ACCESS && !wr_q) ? ce_hot : '0;
   assign resp_valid = (state == RESP);
`ifdef IPIF_MASTER_TIMEOUT_EN
   ipif_timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk   (Bus2IP_Clk),
      .rst_n (Bus2IP_Resetn),
      .load  (state == SETUP),
      .enable(state == ACCESS),
      .expire(expire)
   );
`else
   // never fires: ACCESS waits for its ack indefinitely
   assign expire = (TIMEOUT_CYCLES < 0);
`endif
   always_comb begin
      next = (state == IDLE)   ? ((cmd_valid && cmd_ready) ? SETUP : IDLE) :
             (state == SETUP)  ? ACCESS :
             (state == ACCESS) ? ((ack || expire) ? RESP : ACCESS) :
                                 (resp_ready ? IDLE : RESP);
   end
   // cmd_ready is registered so it stays low during reset and rises one edge after release
   always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
      if (!Bus2IP_Resetn) begin
         state        <= IDLE;
         cmd_ready    <= 1'b0;
         wr_q         <= 1'b0;
         reg_q        <= '0;
         Bus2IP_Data  <= '0;
         Bus2IP_BE    <= '0;
         resp_data    <= '0;
         resp_err     <= 1'b0;
         resp_timeout <= 1'b0;
      end else begin
         state     <= next;
         cmd_ready <= (next == IDLE);
         if (state == IDLE && cmd_valid && cmd_ready) begin
            wr_q        <= cmd_write;
            reg_q       <= cmd_reg;
            Bus2IP_Data <= cmd_data;
            Bus2IP_BE   <= cmd_be;
         end
         // ack wins over a simultaneous timeout expiry
         if (state == ACCESS && (ack || expire)) begin
            resp_data    <= (ack && !wr_q) ? IP2Bus_Data : '0;
            resp_err     <= ack ? IP2Bus_Error : 1'b1;
            resp_timeout <= !ack;
         end
      end
   end
endmodule

// File: tb/tb_ipif_bus_master.sv
// tb_ipif_bus_master: randomized self-checking bench for ipif_bus_master (NUM_CE=2).
module tb_ipif_bus_master;
   logic        Bus2IP_Clk = 1'b0;
   logic        Bus2IP_Resetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [0:0]  cmd_reg;
   logic [31:0] cmd_data;
   logic [3:0]  cmd_be;
   logic        resp_valid, resp_ready, resp_err, resp_timeout;
   logic [31:0] resp_data;
   logic [31:0] Bus2IP_Data;
   logic [3:0]  Bus2IP_BE;
   logic [1:0]  Bus2IP_RdCE, Bus2IP_WrCE;
   logic [31:0] IP2Bus_Data;
   logic        IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error;
   int n_checks = 0;
   int n_fail = 0;

   ipif_bus_master #(.NUM_CE(2), .TIMEOUT_CYCLES(16)) dut (
      .Bus2IP_Clk   (Bus2IP_Clk),
      .Bus2IP_Resetn(Bus2IP_Resetn),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_write    (cmd_write),
      .cmd_reg      (cmd_reg),
      .cmd_data     (cmd_data),
      .cmd_be       (cmd_be),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_err     (resp_err),
      .resp_timeout (resp_timeout),
      .Bus2IP_Data  (Bus2IP_Data),
      .Bus2IP_BE    (Bus2IP_BE),
      .Bus2IP_RdCE  (Bus2IP_RdCE),
      .Bus2IP_WrCE  (Bus2IP_WrCE),
      .IP2Bus_Data  (IP2Bus_Data),
      .IP2Bus_RdAck (IP2Bus_RdAck),
      .IP2Bus_WrAck (IP2Bus_WrAck),
      .IP2Bus_Error (IP2Bus_Error)
   );

   always #5 Bus2IP_Clk = ~Bus2IP_Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction, starting at a negedge with the master idle. The slave acks
   // in the n-th ACCESS cycle (never, if noack). decoy puts a matching ack in
   // SETUP and a wrong-direction ack in the first ACCESS cycle.
   task automatic run_txn(input bit wr, input int rg, input logic [31:0] d, input logic [3:0] be,
                          input int n, input bit err, input logic [31:0] rd, input bit decoy,
                          input bit noack);
      logic [1:0]  ce_exp;
      logic [31:0] dat_exp;
      bit          err_exp, to_exp;
      int          w, cnt;
      ce_exp  = (rg == 0) ? 2'b10 : 2'b01;
      dat_exp = (noack || wr) ? 32'h0 : rd;
      err_exp = noack ? 1'b1 : err;
      to_exp  = noack;
      cmd_write = wr; cmd_reg = rg[0]; cmd_data = d; cmd_be = be; cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 10) begin
         @(negedge Bus2IP_Clk);
         w++;
      end
      if (!cmd_ready) begin
         check("ready_wait", 32'(cmd_ready), 1);
         cmd_valid = 1'b0;
         return;
      end
      @(negedge Bus2IP_Clk);
      cmd_valid = 1'b0; cmd_write = !wr; cmd_reg = !rg[0]; cmd_data = ~d; cmd_be = ~be;
      check("setup_data", Bus2IP_Data, d);
      check("setup_be", 32'(Bus2IP_BE), 32'(be));
      check("setup_ce", 32'({Bus2IP_WrCE, Bus2IP_RdCE}), 0);
      check("setup_ready", 32'(cmd_ready), 0);
      if (decoy) begin
         if (wr) IP2Bus_WrAck = 1'b1; else IP2Bus_RdAck = 1'b1;
      end
      @(negedge Bus2IP_Clk);
      IP2Bus_WrAck = 1'b0; IP2Bus_RdAck = 1'b0;
      cnt = 0;
      for (int c = 1; c <= n; c++) begin
         if ((wr ? Bus2IP_WrCE : Bus2IP_RdCE) == ce_exp && (wr ? Bus2IP_RdCE : Bus2IP_WrCE) == 2'b00)
            cnt++;
         check("access_data", Bus2IP_Data, d);
         IP2Bus_Data  = (c == n) ? rd : $urandom;
         IP2Bus_Error = (c == n) ? err : 1'($urandom);
         if (wr) begin
            IP2Bus_WrAck = (c == n) && !noack;
            IP2Bus_RdAck = decoy && c == 1;
         end else begin
            IP2Bus_RdAck = (c == n) && !noack;
            IP2Bus_WrAck = decoy && c == 1;
         end
         @(negedge Bus2IP_Clk);
      end
      IP2Bus_WrAck = 1'b0; IP2Bus_RdAck = 1'b0; IP2Bus_Error = 1'b0;
      check("ce_cycles", 32'(cnt), 32'(n));
      check("resp_ce_off", 32'({Bus2IP_WrCE, Bus2IP_RdCE}), 0);
      check("resp_valid", 32'(resp_valid), 1);
      check("resp_data", resp_data, dat_exp);
      check("resp_err", 32'(resp_err), 32'(err_exp));
      check("resp_timeout", 32'(resp_timeout), 32'(to_exp));
      repeat ($urandom_range(0, 2)) begin
         @(negedge Bus2IP_Clk);
         check("hold_valid", 32'(resp_valid), 1);
         check("hold_data", resp_data, dat_exp);
      end
      resp_ready = 1'b1;
      @(negedge Bus2IP_Clk);
      resp_ready = 1'b0;
      check("done_valid", 32'(resp_valid), 0);
      check("done_ready", 32'(cmd_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      Bus2IP_Resetn = 1'b0;
      cmd_valid = 0; cmd_write = 0; cmd_reg = 0; cmd_data = 0; cmd_be = 0; resp_ready = 0;
      IP2Bus_Data = 0; IP2Bus_RdAck = 0; IP2Bus_WrAck = 0; IP2Bus_Error = 0;
      #1;
      check("rst_ready", 32'(cmd_ready), 0);
      check("rst_ce", 32'({Bus2IP_WrCE, Bus2IP_RdCE}), 0);
      check("rst_valid", 32'(resp_valid), 0);
      check("rst_bus_data", Bus2IP_Data, 0);
      check("rst_resp", {resp_data[30:0], resp_err}, 0);
      repeat (2) @(negedge Bus2IP_Clk);
      Bus2IP_Resetn = 1'b1;
      @(negedge Bus2IP_Clk);
      check("rel_ready", 32'(cmd_ready), 1);
      // directed scenarios
      run_txn(1, 1, 32'h2, 4'hF, 1, 0, 32'h0, 0, 0);
      run_txn(0, 0, 32'h0, 4'hF, 3, 0, 32'h5, 0, 0);
      run_txn(1, 0, 32'hA5A5_0001, 4'h3, 3, 0, 32'hDEAD_BEEF, 1, 0);
      run_txn(0, 1, 32'h0, 4'hF, 2, 1, 32'h1234_5678, 0, 0);
      run_txn(0, 0, 32'h0, 4'hF, 16, 0, 32'hCAFE_F00D, 0, 0);
`ifdef IPIF_MASTER_TIMEOUT_EN
      run_txn(1, 1, 32'h77, 4'hF, 16, 0, 32'h0, 0, 1);
      run_txn(0, 0, 32'h0, 4'hF, 16, 0, 32'hFFFF_0000, 0, 1);
`endif
      // randomized traffic
      for (int t = 0; t < 20; t++) begin
         int n_r;
         bit dec;
         n_r = $urandom_range(1, 5);
         dec = (n_r > 1) && ($urandom_range(0, 1) == 1);
         run_txn($urandom_range(0, 1) == 1, $urandom_range(0, 1), $urandom, 4'($urandom), n_r,
                 $urandom_range(0, 1) == 1, $urandom, dec, 0);
      end
      // reset in the middle of ACCESS
      cmd_write = 1'b1; cmd_reg = 1'b0; cmd_data = 32'h1111_2222; cmd_be = 4'hF; cmd_valid = 1'b1;
      @(negedge Bus2IP_Clk);
      cmd_valid = 1'b0;
      @(negedge Bus2IP_Clk);
      check("mid_ce", 32'(Bus2IP_WrCE), 32'h2);
      #2 Bus2IP_Resetn = 1'b0;
      #1;
      check("mid_rst_ce", 32'({Bus2IP_WrCE, Bus2IP_RdCE}), 0);
      check("mid_rst_valid", 32'(resp_valid), 0);
      check("mid_rst_data", Bus2IP_Data, 0);
      check("mid_rst_ready", 32'(cmd_ready), 0);
      @(negedge Bus2IP_Clk);
      IP2Bus_WrAck = 1'b1;
      @(negedge Bus2IP_Clk);
      IP2Bus_WrAck = 1'b0;
      Bus2IP_Resetn = 1'b1;
      check("mid_rel_ready0", 32'(cmd_ready), 0);
      @(negedge Bus2IP_Clk);
      check("mid_rel_ready1", 32'(cmd_ready), 1);
      check("mid_rel_valid", 32'(resp_valid), 0);
      run_txn(0, 1, 32'h0, 4'hF, 2, 0, 32'h0BAD_F00D, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
